// File: rtl/pipe_pkg.sv
// Shared pipeline constants: opcodes, datapath width and the no-write opcode predicate.
package pipe_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [5:0] OP_BUBBLE = 6'd55;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_JAL    = 6'd3;
    localparam logic [5:0] OP_SW     = 6'd43;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_BNE    = 6'd5;
    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_HALT   = 6'd63;

    // Opcodes that never commit a register write regardless of wreg.
    function automatic logic is_no_write_op(input logic [5:0] op);
        return op inside {OP_BUBBLE, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT};
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Writeback-stage bundle: EX/WB inputs, decode read ports and writeback/status outputs.
// Carries retire_cnt only when WB_RETIRE_CNT_EN is defined.
interface wb_stage_if;
    import pipe_pkg::*;

    logic [5:0]      op_in;
    logic [XLEN-1:0] pc_in;
    logic [4:0]      wreg_in;
    logic [XLEN-1:0] alu_result_in;
    logic [XLEN-1:0] dm_data_in;
    logic [4:0]      rs_addr;
    logic [4:0]      rt_addr;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            wb_en;
    logic [4:0]      wb_reg;
    logic [XLEN-1:0] wb_data;
    logic            halted;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]     retire_cnt;
`endif

    modport master (
        output op_in, pc_in, wreg_in, alu_result_in, dm_data_in, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_en, wb_reg, wb_data, halted
`ifdef WB_RETIRE_CNT_EN
        , input retire_cnt
`endif
    );

    modport slave (
        input  op_in, pc_in, wreg_in, alu_result_in, dm_data_in, rs_addr, rt_addr,
        output rs_data, rt_data, wb_en, wb_reg, wb_data, halted
`ifdef WB_RETIRE_CNT_EN
        , output retire_cnt
`endif
    );

endinterface

// File: rtl/regfile_2r1w.sv
// Two-read one-write register file with async clear, hardwired zero register
// and same-cycle write-to-read bypass.
module regfile_2r1w #(
    parameter int unsigned RF_DEPTH = 32,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rstd,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr_a,
    input  logic [4:0]      i_raddr_b,
    output logic [XLEN-1:0] o_rdata_a,
    output logic [XLEN-1:0] o_rdata_b
);

    logic [XLEN-1:0] r_mem [RF_DEPTH];

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            for (int i = 0; i < int'(RF_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0) && (32'(i_waddr) < RF_DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads are forced to zero while reset is asserted so the ports are clean
    // even if upstream has not yet settled to a bubble.
    always_comb begin
        o_rdata_a = '0;
        if (rstd && (i_raddr_a != 5'd0) && (32'(i_raddr_a) < RF_DEPTH)) begin
            if (i_we && (i_raddr_a == i_waddr)) begin
                o_rdata_a = i_wdata;
            end else begin
                o_rdata_a = r_mem[i_raddr_a];
            end
        end
    end

    always_comb begin
        o_rdata_b = '0;
        if (rstd && (i_raddr_b != 5'd0) && (32'(i_raddr_b) < RF_DEPTH)) begin
            if (i_we && (i_raddr_b == i_waddr)) begin
                o_rdata_b = i_wdata;
            end else begin
                o_rdata_b = r_mem[i_raddr_b];
            end
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects writeback data, gates the commit, tracks halt and retirement.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter int unsigned RF_DEPTH = 32,
    parameter int unsigned XLEN     = 32
) (
    input logic       clk,
    input logic       rstd,
    wb_stage_if.slave bus
);
    import pipe_pkg::*;

    logic            r_halted;
    logic            w_wb_en;
    logic [XLEN-1:0] w_sel_data;

    always_comb begin
        w_sel_data = bus.alu_result_in;
        if (bus.op_in == OP_LW) begin
            w_sel_data = bus.dm_data_in;
        end else if (bus.op_in == OP_JAL) begin
            w_sel_data = bus.pc_in + XLEN'(4);
        end
    end

    assign w_wb_en     = (bus.wreg_in != 5'd0) && !is_no_write_op(bus.op_in) && !r_halted;
    assign bus.wb_en   = w_wb_en;
    assign bus.wb_reg  = w_wb_en ? bus.wreg_in : 5'd0;
    assign bus.wb_data = w_wb_en ? w_sel_data : '0;
    assign bus.halted  = r_halted;

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_halted <= 1'b0;
        end else if ((bus.op_in == OP_HALT) && !r_halted) begin
            r_halted <= 1'b1;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    // HALT itself retires because the check uses the pre-edge halted value.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_retire_cnt <= '0;
        end else if ((bus.op_in != OP_BUBBLE) && !r_halted) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign bus.retire_cnt = r_retire_cnt;
`endif

    regfile_2r1w #(
        .RF_DEPTH (RF_DEPTH),
        .XLEN     (XLEN)
    ) u_regfile (
        .clk       (clk),
        .rstd      (rstd),
        .i_we      (w_wb_en),
        .i_waddr   (bus.wreg_in),
        .i_wdata   (w_sel_data),
        .i_raddr_a (bus.rs_addr),
        .i_raddr_b (bus.rt_addr),
        .o_rdata_a (bus.rs_data),
        .o_rdata_b (bus.rt_data)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against an instruction-level reference model.
module tb_wb_stage;
    import pipe_pkg::*;

    logic clk;
    logic rstd;
    int   n_checks;
    int   n_fail;

    logic [31:0] m_rf [32];
    logic        m_halted;
    logic [31:0] m_cnt;

    wb_stage_if bus ();

    wb_stage #(
        .RF_DEPTH (32),
        .XLEN     (32)
    ) dut (
        .clk  (clk),
        .rstd (rstd),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_halted = 1'b0;
        m_cnt    = 32'd0;
    endtask

    // Called at a negedge; returns at the following negedge with the model advanced.
    task automatic apply(input logic [5:0] op, input logic [31:0] pc, input logic [4:0] wreg,
                         input logic [31:0] alu, input logic [31:0] dm,
                         input logic [4:0] rs, input logic [4:0] rt);
        logic        wen;
        logic [31:0] data;
        logic [31:0] nxt [32];
        bus.op_in = op;
        bus.pc_in = pc;
        bus.wreg_in = wreg;
        bus.alu_result_in = alu;
        bus.dm_data_in = dm;
        bus.rs_addr = rs;
        bus.rt_addr = rt;
        #1;
        wen = (wreg != 0) && !m_halted &&
              !(op == 6'd55 || op == 6'd43 || op == 6'd4 || op == 6'd5 || op == 6'd2 || op == 6'd63);
        data = (op == 6'd35) ? dm : (op == 6'd3) ? pc + 32'd4 : alu;
        // Register-file contents as they will be after this edge; reads see this state.
        nxt = m_rf;
        if (wen) nxt[wreg] = data;
        nxt[0] = 32'd0;
        check("wb_en", 32'(bus.wb_en), 32'(wen));
        check("wb_reg", 32'(bus.wb_reg), wen ? 32'(wreg) : 32'd0);
        check("wb_data", bus.wb_data, wen ? data : 32'd0);
        check("rs_data", bus.rs_data, nxt[rs]);
        check("rt_data", bus.rt_data, nxt[rt]);
        check("halted", 32'(bus.halted), 32'(m_halted));
`ifdef WB_RETIRE_CNT_EN
        check("retire_cnt", bus.retire_cnt, m_cnt);
`endif
        @(posedge clk);
        if (op != 6'd55 && !m_halted) m_cnt = m_cnt + 32'd1;
        if (op == 6'd63) m_halted = 1'b1;
        m_rf = nxt;
        @(negedge clk);
    endtask

    task automatic bubble_read(input logic [4:0] rs, input logic [4:0] rt);
        apply(6'd55, 32'd0, 5'd0, 32'd0, 32'd0, rs, rt);
    endtask

    task automatic do_reset();
        bus.op_in = 6'd55;
        bus.wreg_in = 5'd0;
        bus.rs_addr = 5'd4;
        bus.rt_addr = 5'd31;
        #2;
        rstd = 1'b0;
        #1;
        check("rst_rs", bus.rs_data, 32'd0);
        check("rst_rt", bus.rt_data, 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_wb_en", 32'(bus.wb_en), 32'd0);
`ifdef WB_RETIRE_CNT_EN
        check("rst_cnt", bus.retire_cnt, 32'd0);
`endif
        model_clear();
        @(negedge clk);
        rstd = 1'b1;
    endtask

    logic [5:0] rand_ops [12] = '{6'd0, 6'd1, 6'd8, 6'd12, 6'd13, 6'd35,
                                  6'd3, 6'd43, 6'd4, 6'd5, 6'd2, 6'd55};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstd     = 1'b0;
        bus.op_in = 6'd55;
        bus.pc_in = '0;
        bus.wreg_in = '0;
        bus.alu_result_in = '0;
        bus.dm_data_in = '0;
        bus.rs_addr = '0;
        bus.rt_addr = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // ALU write then readback; LW and JAL select.
        apply(6'd0, 32'h0, 5'd5, 32'h1234, 32'h0, 5'd5, 5'd0);
        bubble_read(5'd5, 5'd5);
        apply(6'd35, 32'h0, 5'd7, 32'hAAAA, 32'hBEEF, 5'd0, 5'd0);
        apply(6'd3, 32'h100, 5'd31, 32'h0, 32'h0, 5'd7, 5'd0);
        bubble_read(5'd7, 5'd31);
        check("lw_r7", bus.rs_data, 32'hBEEF);
        check("jal_r31", bus.rt_data, 32'h104);

        // Suppression: bubble, SW, r0.
        apply(6'd0, 32'h0, 5'd9, 32'h99, 32'h0, 5'd0, 5'd0);
        apply(6'd55, 32'h0, 5'd9, 32'h1111, 32'h0, 5'd9, 5'd0);
        apply(6'd43, 32'h0, 5'd9, 32'h2222, 32'h0, 5'd9, 5'd0);
        apply(6'd0, 32'h0, 5'd0, 32'hFFFF, 32'h0, 5'd0, 5'd9);
        check("r9_kept", bus.rt_data, 32'h99);

        // Same-cycle bypass to both ports.
        apply(6'd0, 32'h0, 5'd12, 32'h55, 32'h0, 5'd12, 5'd12);

        // Randomized stream without HALT.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr;
            wr = 5'($urandom_range(0, 31));
            apply(rand_ops[$urandom_range(0, 11)], $urandom, wr, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)));
        end

        // Halt sequence from a clean state.
        do_reset();
        apply(6'd0, 32'h0, 5'd1, 32'h11, 32'h0, 5'd0, 5'd0);
        apply(6'd55, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        apply(6'd0, 32'h0, 5'd2, 32'h22, 32'h0, 5'd0, 5'd0);
        apply(6'd63, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        apply(6'd0, 32'h0, 5'd3, 32'h9, 32'h0, 5'd3, 5'd0);
        bubble_read(5'd3, 5'd2);
        check("halt_flag", 32'(bus.halted), 32'd1);
        check("halt_r3", bus.rs_data, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        check("halt_cnt", bus.retire_cnt, 32'd3);
`endif
        for (int n = 0; n < 20; n++) begin
            apply(rand_ops[$urandom_range(0, 11)], $urandom, 5'($urandom_range(0, 31)),
                  $urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Counter wrap.
        do_reset();
`ifdef WB_RETIRE_CNT_EN
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        m_cnt = 32'hFFFF_FFFF;
        apply(6'd0, 32'h0, 5'd6, 32'h6, 32'h0, 5'd0, 5'd0);
        check("cnt_wrap", bus.retire_cnt, 32'd0);
`endif

        // Async reset mid-stream, between edges.
        apply(6'd0, 32'h0, 5'd4, 32'h77, 32'h0, 5'd0, 5'd0);
        apply(6'd63, 32'h0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd4);
        check("pre_rst_r4", bus.rs_data, 32'h77);
        do_reset();
        bubble_read(5'd4, 5'd4);
        apply(6'd0, 32'h0, 5'd4, 32'h5A, 32'h0, 5'd4, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage and architectural register file. It consumes the EX/WB pipeline register outputs (op, pc, wreg, ALU result, data-memory read data) and selects the writeback value. It commits that value to a 32×32-bit register file and serves the two decode-stage read ports with same-cycle write bypass. It also exposes the current writeback for forwarding and tracks retirement and halt status.

## Interface
Parameters:
- RF_DEPTH, 32, number of architectural registers; index width fixed at 5.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstd  in  1  reset; asynchronous, active-low.
- op_in  in  6  opcode from EX/WB register; 6'd55 = bubble.
- pc_in  in  32  PC of the instruction in writeback.
- wreg_in  in  5  destination register; 0 = none.
- alu_result_in  in  32  ALU result.
- dm_data_in  in  32  data-memory load data.
- rs_addr  in  5  decode read port A index.
- rt_addr  in  5  decode read port B index.
- rs_data  out  32  read port A data, combinational.
- rt_data  out  32  read port B data, combinational.
- wb_en  out  1  this cycle commits a register write.
- wb_reg  out  5  register being written; 0 when wb_en=0.
- wb_data  out  32  value being written; 0 when wb_en=0.
- halted  out  1  sticky; a HALT has retired.
- retire_cnt  out  32  retired non-bubble instructions (only with WB_RETIRE_CNT_EN).

## Operation
- Opcodes: BUBBLE=55, LW=35, JAL=3, SW=43, BEQ=4, BNE=5, J=2, HALT=63.
- Write data select: LW → dm_data_in; JAL → pc_in + 4 (mod 2^32); all other ops → alu_result_in.
- wb_en = (wreg_in != 0) && op_in ∉ {BUBBLE, SW, BEQ, BNE, J, HALT} && !halted.
- When wb_en=1, regfile[wreg_in] ← wb_data at the rising edge.
- Register 0 is never written and always reads 0.
- Read ports: if the address is 0, output 0. Otherwise, if wb_en and the address equals wb_reg, output wb_data (bypass). Otherwise output regfile[address].
- HALT retiring (op_in==63, !halted) sets halted at the edge. Once halted, no further writes occur and no further retire counting occurs until reset.
- Retire: each edge with op_in != 55 and !halted increments retire_cnt. The HALT itself counts. The counter wraps 0xFFFFFFFF → 0.

## Timing
- Write latency: data is visible in the array one edge after wb_en. It is visible on the read ports in the same cycle via the bypass.
- wb_en, wb_reg and wb_data are combinational from the inputs and halted, with zero latency.
- Reset (asynchronous, any time, including mid-stream):
  - All 31 writable registers clear to 0.
  - halted=0; retire_cnt=0.
  - rs_data=rt_data=0.
  - wb_en/wb_reg/wb_data follow the inputs. Upstream holds op=55 during reset, so these outputs are 0.
- First edge after rstd deasserts: normal operation.
- Simultaneous write and read to the same register: the read returns the new value.
- Both ports may read the same register.

## Configuration
- WB_RETIRE_CNT_EN defined: the retire_cnt port and its 32-bit counter exist, behaving as above.
- WB_RETIRE_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - opcode constants OP_BUBBLE, OP_LW, OP_JAL, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT;
  - XLEN;
  - the no-write opcode predicate as a function.
- One sub-module: regfile_2r1w. It contains the array, async clear, the zero-register rule and the bypass.
- wb_stage contains write-data selection, enable logic, the halt flag and the counter.

## Test plan
- Reset then ALU op: op=0, wreg=5, alu=0x1234 → wb_en=1, wb_data=0x1234; after the edge, rs_addr=5 reads 0x1234.
- LW vs ALU select: op=35, wreg=7, alu=0xAAAA, dm=0xBEEF → regfile[7]=0xBEEF. JAL: op=3, wreg=31, pc=0x100 → regfile[31]=0x104.
- Suppression:
  - bubble op=55 with wreg=9 → wb_en=0 and regfile[9] is unchanged;
  - SW with wreg=9 → no write;
  - wreg=0 with alu=0xFFFF → r0 still reads 0.
- Bypass: same cycle, op=0, wreg=12, alu=0x55, rs_addr=rt_addr=12 → both ports read 0x55 before the edge.
- Halt and counter:
  - sequence ALU, bubble, ALU, HALT, ALU(wreg=3, alu=9) → retire_cnt=3, halted=1, regfile[3] unchanged;
  - counter preloaded to 0xFFFFFFFF plus one retire → 0.
- Async reset mid-stream: assert rstd low between edges after writing r4=0x77 → rs_data(4)=0, halted=0, retire_cnt=0 immediately without a clock edge.
